texture_palette_lut: RTL and testbench

// - Runtime-loadable, multi-texture colour palette for the renderer's texture stage.
// - Maps a (texture id, 8-bit colour index) pair to 12-bit RGB through a 2-stage pipeline.
// - Applies optional per-pixel brightness shading and flags one transparent key index.
// - Replaces the fixed per-texture palettes: texture loader writes palettes after reset,
//   and the raster pipeline reads them.

---
 rtl/texture_palette_lut.sv | 180 ++++++++++++++++++
 tb/tb_texture_palette_lut.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/texture_palette_lut.sv
// Multi-texture 12-bit RGB palette: self-clearing RAM, runtime loading, 2-stage lookup.
// Optional brightness shading multiplier enabled by defining TEX_PAL_SHADE_EN.
module texture_palette_lut #(
  parameter int  NUM_TEX = 4,
  parameter int  IDX_W   = 8,
  parameter int  CH_W    = 4,
  parameter int  SHADE_W = 4,
  parameter int  KEY_IDX = 0,
  localparam int TEX_W   = (NUM_TEX > 1) ? $clog2(NUM_TEX) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [TEX_W-1:0]   ld_tex,
  input  logic [IDX_W-1:0]   ld_idx,
  input  logic [3*CH_W-1:0]  ld_rgb,
  input  logic               rd_valid,
  input  logic [TEX_W-1:0]   rd_tex,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic [SHADE_W-1:0] rd_shade,
  output logic               out_valid,
  output logic               out_transp,
  output logic [CH_W-1:0]    red,
  output logic [CH_W-1:0]    green,
  output logic [CH_W-1:0]    blue
);

  localparam int ADDR_W = TEX_W + IDX_W;
  localparam int DEPTH  = NUM_TEX << IDX_W;
  localparam int RGB_W  = 3 * CH_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [TEX_W:0]    TEX_LIMIT = (TEX_W + 1)'(NUM_TEX);
  localparam logic [IDX_W-1:0]  KEY       = IDX_W'(KEY_IDX);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_clr_cnt;

  logic               w_ld_tex_ok;
  logic               w_rd_tex_ok;
  logic               w_rd_fire;
  logic               w_we;
  logic [ADDR_W-1:0]  w_waddr;
  logic [RGB_W-1:0]   w_wdata;

  logic [RGB_W-1:0]   r_mem [DEPTH];
  logic [RGB_W-1:0]   r_rd_word;

  logic               r_s1_valid;
  logic               r_s1_tex_ok;
  logic [IDX_W-1:0]   r_s1_idx;
  logic [CH_W-1:0]    w_red;
  logic [CH_W-1:0]    w_green;
  logic [CH_W-1:0]    w_blue;

  logic               r_out_valid;
  logic               r_out_transp;
  logic [CH_W-1:0]    r_red;
  logic [CH_W-1:0]    r_green;
  logic [CH_W-1:0]    r_blue;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_INIT;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
    end
  end

  // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_clr_cnt == LAST_ADDR) w_state_nxt = ST_RUN;
  end

  assign ld_ready    = (r_state == ST_RUN);
  assign w_ld_tex_ok = ({1'b0, ld_tex} < TEX_LIMIT);
  assign w_rd_tex_ok = ({1'b0, rd_tex} < TEX_LIMIT);
  assign w_rd_fire   = rd_valid && (r_state == ST_RUN);

  // Single write port shared by the power-up clear and the texture loader.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_clr_cnt;
    w_wdata = '0;
    if (r_state == ST_INIT) begin
      w_we = 1'b1;
    end else if (ld_valid && w_ld_tex_ok) begin
      w_we    = 1'b1;
      w_waddr = {ld_tex, ld_idx};
      w_wdata = ld_rgb;
    end
  end

  // NOTE: the RAM has no reset; the INIT sweep zeroes it so it maps onto block RAM.
  // A same-address read in the write cycle returns the old word.
  always_ff @(posedge Clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    if (w_rd_fire && w_rd_tex_ok) r_rd_word <= r_mem[{rd_tex, rd_idx}];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_tex_ok <= 1'b0;
      r_s1_idx    <= '0;
    end else begin
      r_s1_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_s1_tex_ok <= w_rd_tex_ok;
        r_s1_idx    <= rd_idx;
      end
    end
  end

`ifdef TEX_PAL_SHADE_EN
  localparam int PROD_W = CH_W + SHADE_W + 1;

  logic [SHADE_W-1:0] r_s1_shade;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)          r_s1_shade <= '0;
    else if (w_rd_fire) r_s1_shade <= rd_shade;
  end

  function automatic logic [CH_W-1:0] shade_ch(input logic [CH_W-1:0]    ch,
                                               input logic [SHADE_W-1:0] s);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(ch) * (PROD_W'(s) + PROD_W'(1));
    return prod[SHADE_W +: CH_W];
  endfunction

  always_comb begin
    w_red   = shade_ch(r_rd_word[2*CH_W +: CH_W], r_s1_shade);
    w_green = shade_ch(r_rd_word[CH_W   +: CH_W], r_s1_shade);
    w_blue  = shade_ch(r_rd_word[0      +: CH_W], r_s1_shade);
  end
`else
  logic w_unused_shade;
  assign w_unused_shade = ^rd_shade;

  always_comb begin
    w_red   = r_rd_word[2*CH_W +: CH_W];
    w_green = r_rd_word[CH_W   +: CH_W];
    w_blue  = r_rd_word[0      +: CH_W];
  end
`endif

  // Colours hold their last value while no result is valid; out-of-range textures read as 0.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_out_valid  <= 1'b0;
      r_out_transp <= 1'b0;
      r_red        <= '0;
      r_green      <= '0;
      r_blue       <= '0;
    end else begin
      r_out_valid  <= r_s1_valid;
      r_out_transp <= r_s1_valid && r_s1_tex_ok && (r_s1_idx == KEY);
      if (r_s1_valid) begin
        r_red   <= r_s1_tex_ok ? w_red   : '0;
        r_green <= r_s1_tex_ok ? w_green : '0;
        r_blue  <= r_s1_tex_ok ? w_blue  : '0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_transp = r_out_transp;
  assign red        = r_red;
  assign green      = r_green;
  assign blue       = r_blue;

endmodule

// File: tb/tb_texture_palette_lut.sv
// Self-checking bench for texture_palette_lut: vector table plus scoreboard queue.
// Expectations for shading follow TEX_PAL_SHADE_EN exactly as the design build does.
module tb_texture_palette_lut;

  localparam int NUM_TEX = 4;
  localparam int NENT    = 256;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [1:0]  ld_tex = '0;
  logic [7:0]  ld_idx = '0;
  logic [11:0] ld_rgb = '0;
  logic        rd_valid = 1'b0;
  logic [1:0]  rd_tex = '0;
  logic [7:0]  rd_idx = '0;
  logic [3:0]  rd_shade = '0;
  logic        out_valid;
  logic        out_transp;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;

  texture_palette_lut dut (
    .Clk(Clk), .Reset(Reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_tex(ld_tex), .ld_idx(ld_idx), .ld_rgb(ld_rgb),
    .rd_valid(rd_valid), .rd_tex(rd_tex), .rd_idx(rd_idx), .rd_shade(rd_shade),
    .out_valid(out_valid), .out_transp(out_transp), .red(red), .green(green), .blue(blue)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        transp;
    logic [11:0] rgb;
  } exp_t;

  typedef struct {
    bit          wr;
    int          tex;
    int          idx;
    logic [11:0] wdata;
    logic [3:0]  shade;
    logic [11:0] exp_rgb;
  } vec_t;

  exp_t        sb_q[$];
  logic [11:0] model_mem [NUM_TEX][NENT];
  vec_t        vecs[7];
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          ov_seen = 0;
  bit          tb_run = 1'b0;
  logic [11:0] last_rgb = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_colour(input logic [11:0] w, input logic [3:0] s);
`ifdef TEX_PAL_SHADE_EN
    int f, r, g, b;
    f = int'(s) + 1;
    r = (int'(w[11:8]) * f) / 16;
    g = (int'(w[7:4]) * f) / 16;
    b = (int'(w[3:0]) * f) / 16;
    return {r[3:0], g[3:0], b[3:0]};
`else
    return w;
`endif
  endfunction

  // Output monitor: every valid result must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (out_valid) begin
      ov_seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("rgb", {20'd0, red, green, blue}, {20'd0, e.rgb});
        check("transp", {31'd0, out_transp}, {31'd0, e.transp});
        last_rgb = e.rgb;
        pops++;
      end
    end else if (!Reset) begin
      check("transp_idle", {31'd0, out_transp}, 32'd0);
    end
  end

  // One cycle of stimulus; expectation taken from the model before this cycle's write.
  task automatic cyc(input bit ldv, input int lt, input int li, input logic [11:0] ld,
                     input bit rv, input int rt, input int ri, input logic [3:0] rs);
    logic [31:0] v;
    ld_valid = ldv;
    v = lt; ld_tex = v[1:0];
    v = li; ld_idx = v[7:0];
    ld_rgb   = ld;
    rd_valid = rv;
    v = rt; rd_tex = v[1:0];
    v = ri; rd_idx = v[7:0];
    rd_shade = rs;
    if (rv && tb_run) sb_q.push_back(exp_t'{transp: (ri == 0), rgb: ref_colour(model_mem[rt][ri], rs)});
    if (ldv && tb_run) model_mem[lt][li] = ld;
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 0, 0, 0, '0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      n++;
      @(negedge Clk);
    end
    check(tag, sb_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    tb_run   = 1'b0;
    ld_valid = 1'b0;
    rd_valid = 1'b0;
    sb_q.delete();
    for (int t = 0; t < NUM_TEX; t++)
      for (int i = 0; i < NENT; i++) model_mem[t][i] = '0;
    repeat (2) @(negedge Clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_transp", {31'd0, out_transp}, 32'd0);
    check("rst_rgb", {20'd0, red, green, blue}, 32'd0);
    Reset = 1'b0;
  endtask

  // Reads are requested throughout the clear; none may produce a result.
  task automatic wait_clear(input string tag);
    int n;
    int ov0;
    n   = 0;
    ov0 = ov_seen;
    rd_valid = 1'b1;
    while (!ld_ready && n < 3000) begin
      rd_idx = rd_idx + 8'd1;
      n++;
      @(negedge Clk);
    end
    rd_valid = 1'b0;
    check(tag, n, 32'd1024);
    repeat (3) @(negedge Clk);
    check({tag, "_no_out"}, ov_seen - ov0, 32'd0);
    tb_run = 1'b1;
  endtask

  initial begin
    int p0;
    vecs[0] = '{1'b1, 2, 'h10, 12'hC97, 4'hF, 12'hC97};
`ifdef TEX_PAL_SHADE_EN
    vecs[1] = '{1'b0, 2, 'h10, 12'h000, 4'h7, 12'h643};
    vecs[2] = '{1'b1, 0, 'h05, 12'hFFF, 4'h0, 12'h000};
    vecs[5] = '{1'b0, 3, 'hFF, 12'h000, 4'h3, 12'h221};
    vecs[6] = '{1'b1, 0, 'h00, 12'hF0F, 4'h8, 12'h808};
`else
    vecs[1] = '{1'b0, 2, 'h10, 12'h000, 4'h7, 12'hC97};
    vecs[2] = '{1'b1, 0, 'h05, 12'hFFF, 4'h0, 12'hFFF};
    vecs[5] = '{1'b0, 3, 'hFF, 12'h000, 4'h3, 12'h8A4};
    vecs[6] = '{1'b1, 0, 'h00, 12'hF0F, 4'h8, 12'hF0F};
`endif
    vecs[3] = '{1'b1, 3, 'hFF, 12'h8A4, 4'hF, 12'h8A4};
    vecs[4] = '{1'b1, 1, 'h00, 12'h123, 4'hF, 12'h123};

    do_reset();
    wait_clear("clear_cycles");

    for (int i = 0; i < 4; i++) cyc(0, 0, 0, '0, 1, i, (i * 37) % NENT, 4'hF);
    idle(1);
    drain("fresh_reads");

    foreach (vecs[k]) begin
      if (vecs[k].wr) cyc(1, vecs[k].tex, vecs[k].idx, vecs[k].wdata, 0, 0, 0, '0);
      rd_valid = 1'b1;
      rd_tex   = 2'(vecs[k].tex);
      rd_idx   = 8'(vecs[k].idx);
      rd_shade = vecs[k].shade;
      ld_valid = 1'b0;
      sb_q.push_back(exp_t'{transp: (vecs[k].idx == 0), rgb: vecs[k].exp_rgb});
      @(negedge Clk);
      rd_valid = 1'b0;
    end
    idle(1);
    drain("table");

    cyc(1, 1, 'h20, 12'h111, 0, 0, 0, '0);
    cyc(1, 1, 'h20, 12'h555, 1, 1, 'h20, 4'hF);
    cyc(0, 0, 0, '0, 1, 1, 'h20, 4'hF);
    idle(1);
    drain("collision");

    for (int i = 0; i < NENT; i++) cyc(1, 3, i, 12'($urandom), 0, 0, 0, '0);
    p0 = pops;
    for (int i = 0; i < NENT; i++) cyc(0, 0, 0, '0, 1, 3, i, 4'($urandom));
    idle(1);
    drain("stream");
    check("stream_count", pops - p0, 32'd256);

    idle(3);
    check("hold_valid", {31'd0, out_valid}, 32'd0);
    check("hold_rgb", {20'd0, red, green, blue}, {20'd0, last_rgb});

    do_reset();
    rd_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      rd_idx = 8'(i);
      @(negedge Clk);
    end
    check("mid_init_ready", {31'd0, ld_ready}, 32'd0);
    do_reset();
    wait_clear("reclear_cycles");
    cyc(0, 0, 0, '0, 1, 2, 'h10, 4'hF);
    cyc(0, 0, 0, '0, 1, 3, 'hFF, 4'hF);
    idle(1);
    drain("after_reclear");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
